// File: rtl/fp_normalizer_if.sv
// fp_normalizer_if: load/operand/result bundle for fp_normalizer.
// master (requester): drives load, sign_in, exp_in, mant_in; receives result, busy, done, flags.
// slave (normalizer): the reverse.
interface fp_normalizer_if;
    logic        load;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [24:0] mant_in;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        zero_f;
    logic        ovf_f;
    logic        unf_f;
    modport master (
        output load, sign_in, exp_in, mant_in,
        input  result, busy, done, zero_f, ovf_f, unf_f
    );
    modport slave (
        input  load, sign_in, exp_in, mant_in,
        output result, busy, done, zero_f, ovf_f, unf_f
    );
endinterface

// File: rtl/fp_normalizer.sv
// fp_normalizer: iterative single-precision post-normalizer with flush-to-zero.
// Ports: clk, reset (async active-low), bus (slave): load/sign_in/exp_in/mant_in in,
//        result {sign,exp,frac}, busy, done pulse, zero_f/ovf_f/unf_f out.
module fp_normalizer (
    input logic            clk,
    input logic            reset,
    fp_normalizer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
    state_t      state;
    logic        s;
    logic [8:0]  e;
    logic [24:0] m;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            s          <= 1'b0;
            e          <= 9'd0;
            m          <= 25'd0;
            bus.result <= 32'h0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.zero_f <= 1'b0;
            bus.ovf_f  <= 1'b0;
            bus.unf_f  <= 1'b0;
        end else begin
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            if (state == NORM) begin
                if (m[23]) begin
                    bus.result <= {s, e[7:0], m[22:0]};
                    bus.done   <= 1'b1;
                    state      <= DONE;
                end else if (e == 9'd1) begin
                    // one more shift would leave the normal range: flush to zero
                    bus.result <= {s, 31'h0};
                    bus.unf_f  <= 1'b1;
                    bus.done   <= 1'b1;
                    state      <= DONE;
                end else begin
                    m        <= m << 1;
                    e        <= e - 9'd1;
                    bus.busy <= 1'b1;
                end
            end else if (bus.load) begin
                s          <= bus.sign_in;
                e          <= {1'b0, bus.exp_in};
                m          <= bus.mant_in;
                bus.zero_f <= 1'b0;
                bus.ovf_f  <= 1'b0;
                bus.unf_f  <= 1'b0;
                if (bus.mant_in == 25'd0) begin
                    bus.result <= 32'h0;
                    bus.zero_f <= 1'b1;
                    bus.done   <= 1'b1;
                    state      <= DONE;
                end else if (bus.mant_in[24] && bus.exp_in >= 8'hFE) begin
                    bus.result <= {bus.sign_in, 8'hFF, 23'h0};
                    bus.ovf_f  <= 1'b1;
                    bus.done   <= 1'b1;
                    state      <= DONE;
                end else if (bus.mant_in[24]) begin
                    // carry-out: renormalize right by one, fraction LSB is dropped
                    m        <= bus.mant_in >> 1;
                    e        <= {1'b0, bus.exp_in} + 9'd1;
                    bus.busy <= 1'b1;
                    state    <= NORM;
                end else if (bus.exp_in == 8'd0) begin
                    bus.result <= {bus.sign_in, 31'h0};
                    bus.unf_f  <= 1'b1;
                    bus.done   <= 1'b1;
                    state      <= DONE;
                end else begin
                    bus.busy <= 1'b1;
                    state    <= NORM;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: random and directed checks of fp_normalizer against a leading-one model.
module tb_fp_normalizer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    fp_normalizer_if bus();
    fp_normalizer dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
    } exp_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Outcome by leading-one position rather than step-by-step shifting.
    function automatic exp_t model(input logic sg, input logic [7:0] ex, input logic [24:0] mt);
        exp_t r;
        int ee, p, n;
        logic [23:0] mm;
        r.lat = 1;
        if (mt == 25'd0) begin
            r.res = 32'h0; r.flg = 3'b100; return r;
        end
        if (mt[24]) begin
            if (ex >= 8'hFE) begin
                r.res = {sg, 8'hFF, 23'h0}; r.flg = 3'b010; return r;
            end
            mm = mt[24:1];
            ee = int'(ex) + 1;
        end else begin
            if (ex == 8'd0) begin
                r.res = {sg, 31'h0}; r.flg = 3'b001; return r;
            end
            mm = mt[23:0];
            ee = int'(ex);
        end
        p = 23;
        while (!mm[p]) p--;
        n = 23 - p;
        if (n <= ee - 1) begin
            mm = mm << n;
            r.res = {sg, 8'(ee - n), mm[22:0]};
            r.flg = 3'b000;
            r.lat = n + 2;
        end else begin
            r.res = {sg, 31'h0};
            r.flg = 3'b001;
            r.lat = ee + 1;
        end
        return r;
    endfunction

    // Cycle-by-cycle compare, sampled 1 time unit after each rising edge.
    initial begin
        exp_t cur;
        bit active = 0;
        bit was_busy;
        int cyc = 0;
        logic [31:0] hold_res = 32'h0;
        logic [2:0]  hold_flg = 3'b0;
        cur.res = 0; cur.flg = 0; cur.lat = 1;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                active = 0; hold_res = 32'h0; hold_flg = 3'b0;
            end else begin
                was_busy = active && cyc < cur.lat;
                if (bus.load && !was_busy) begin
                    cur = model(bus.sign_in, bus.exp_in, bus.mant_in);
                    active = 1; cyc = 1; hold_flg = 3'b0;
                end else if (active) begin
                    cyc++;
                end
                if (active && cyc == cur.lat) begin
                    hold_res = cur.res; hold_flg = cur.flg;
                end
            end
            chk("busy", {31'h0, bus.busy}, {31'h0, active && cyc < cur.lat});
            chk("done", {31'h0, bus.done}, {31'h0, active && cyc == cur.lat});
            chk("result", bus.result, hold_res);
            chk("flags", {29'h0, bus.zero_f, bus.ovf_f, bus.unf_f}, {29'h0, hold_flg});
            if (active && cyc >= cur.lat) active = 0;
        end
    end

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic op(input string nm, input logic sg, input logic [7:0] ex, input logic [24:0] mt,
                      input bit pulse, input bit lit, input logic [31:0] lres,
                      input logic [2:0] lflg, input int llat);
        int n;
        bus.load = 1'b1; bus.sign_in = sg; bus.exp_in = ex; bus.mant_in = mt;
        @(negedge clk);
        bus.load = pulse;
        bus.sign_in = 1'($urandom); bus.exp_in = 8'($urandom); bus.mant_in = 25'($urandom);
        n = 1;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            bus.load = 1'b0;
            n++;
        end
        bus.load = 1'b0;
        if (!bus.done) begin
            errors++;
            $display("FAIL %s: timeout, no done within %0d cycles", nm, n);
        end
        if (lit) begin
            chk({nm, "_lat"}, n, llat);
            chk({nm, "_res"}, bus.result, lres);
            chk({nm, "_flg"}, {29'h0, bus.zero_f, bus.ovf_f, bus.unf_f}, {29'h0, lflg});
        end
    endtask

    initial begin
        logic [7:0]  ex;
        logic [24:0] mt;
        bus.load = 1'b0; bus.sign_in = 1'b0; bus.exp_in = 8'h0; bus.mant_in = 25'h0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        op("norm0", 1'b0, 8'h80, 25'h0800000, 0, 1, 32'h40000000, 3'b000, 2);
        op("carry", 1'b0, 8'h80, 25'h1000000, 0, 1, 32'h40800000, 3'b000, 2);
        op("ovf",   1'b0, 8'hFE, 25'h1000000, 0, 1, 32'h7F800000, 3'b010, 1);
        op("shift23", 1'b0, 8'h85, 25'h0000001, 0, 1, 32'h37000000, 3'b000, 25);
        op("zero",  1'b1, 8'h42, 25'h0000000, 0, 1, 32'h00000000, 3'b100, 1);
        op("unf",   1'b1, 8'h03, 25'h0000100, 1, 1, 32'h80000000, 3'b001, 4);
        @(negedge clk);
        bus.load = 1'b1; bus.sign_in = 1'b0; bus.exp_in = 8'h85; bus.mant_in = 25'h0000001;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_flags", {29'h0, bus.zero_f, bus.ovf_f, bus.unf_f}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        op("after_rst", 1'b0, 8'h80, 25'h0800000, 0, 1, 32'h40000000, 3'b000, 2);
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0:       mt = 25'h0;
                1:       mt = {1'b1, 24'($urandom)};
                default: mt = 25'($urandom) >> $urandom_range(1, 24);
            endcase
            case ($urandom_range(0, 5))
                0:       ex = 8'h00;
                1:       ex = 8'h01;
                2:       ex = 8'hFE;
                3:       ex = 8'hFF;
                4:       ex = 8'($urandom_range(2, 30));
                default: ex = 8'($urandom);
            endcase
            op("rand", 1'($urandom), ex, mt, ($urandom_range(0, 3) == 0), 0, 32'h0, 3'b0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
